// File: rtl/piped_dot_mac.sv
// piped_dot_mac -- multi-lane pipelined multiply-accumulate engine.
//
// Each accepted launch carries a LANES-wide dot product (sum of a_i*b_i)
// through STAGES pipeline stages. When the operation enters the output
// stage, the dot product is added to the running accumulator, or to zero
// when the operation was launched with clr_acc_n low. The stages form a
// ready/valid chain, so a stalled consumer backs the pipeline up to the
// launch port instead of losing results.
//
// Ports:
//   clk          clock, every state update on the rising edge
//   rst          synchronous active-high reset, overrides every other input
//   init_n       synchronous active-low soft init, same effect as rst
//   clr_acc_n    active-low, sampled with launch: this op starts from zero
//   a, b         operand lanes, lane i at [i*WIDTH +: WIDTH]
//   launch       operation request
//   launch_id    tag that travels with the operation
//   accept_n     active-low, consumer takes the result in the output stage
//   acc          accumulator register
//   arrive       output stage holds a valid result
//   arrive_id    tag of the result in the output stage
//   push_out_n   active-low, low while a result is handed over this cycle
//   pipe_full    no launch can be accepted this cycle
//   pipe_ovf     sticky, a launch was dropped because the pipe was full
//   pipe_census  number of valid stages
//   sat_flag     sticky, the accumulator clamped (only with SAT=1)
module piped_dot_mac #(
  parameter int A_WIDTH   = 8,
  parameter int B_WIDTH   = 8,
  parameter int LANES     = 4,
  parameter int ACC_WIDTH = 24,
  parameter int TC        = 0,
  parameter int STAGES    = 2,
  parameter int ID_WIDTH  = 1,
  parameter int SAT       = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     init_n,
  input  logic                     clr_acc_n,
  input  logic [LANES*A_WIDTH-1:0] a,
  input  logic [LANES*B_WIDTH-1:0] b,
  input  logic                     launch,
  input  logic [ID_WIDTH-1:0]      launch_id,
  input  logic                     accept_n,
  output logic [ACC_WIDTH-1:0]     acc,
  output logic                     arrive,
  output logic [ID_WIDTH-1:0]      arrive_id,
  output logic                     push_out_n,
  output logic                     pipe_full,
  output logic                     pipe_ovf,
  output logic [2:0]               pipe_census,
  output logic                     sat_flag
);

  // Product width, full-precision dot-product width, and the width used for
  // the final add so that overflow of the accumulator is always visible.
  localparam int PW    = A_WIDTH + B_WIDTH;
  localparam int SUM_W = PW + $clog2(LANES) + 1;
  localparam int RES_W = ((ACC_WIDTH > SUM_W) ? ACC_WIDTH : SUM_W) + 1;
  localparam int HI_W  = RES_W - ACC_WIDTH + 1;

  genvar gi;

  // Lane product. Operands are widened to PW bits first (sign- or
  // zero-extended), so the low PW bits of the plain product are exact in
  // both arithmetic modes.
  function automatic logic [PW-1:0] mul_lane(input logic [A_WIDTH-1:0] x,
                                             input logic [B_WIDTH-1:0] y);
    logic [PW-1:0] xe;
    logic [PW-1:0] ye;
    xe = {{B_WIDTH{(TC != 0) & x[A_WIDTH-1]}}, x};
    ye = {{A_WIDTH{(TC != 0) & y[B_WIDTH-1]}}, y};
    return xe * ye;
  endfunction

  // Sum of all lane products at full precision.
  function automatic logic [SUM_W-1:0] sum_lanes(input logic [LANES*PW-1:0] p);
    logic [SUM_W-1:0] s;
    logic [PW-1:0]    t;
    s = '0;
    for (int l = 0; l < LANES; l++) begin
      t = p[l*PW +: PW];
      s = s + {{(SUM_W-PW){(TC != 0) & t[PW-1]}}, t};
    end
    return s;
  endfunction

  // ---------------------------------------------------------------------
  // Control state: one valid bit and one tag per stage.
  // ---------------------------------------------------------------------
  logic [STAGES:1]      valid_q;
  logic [ID_WIDTH-1:0]  id_q [1:STAGES];
  logic [ACC_WIDTH-1:0] acc_q;
  logic                 ovf_q;
  logic                 sat_q;

  logic                 flush;
  logic [STAGES:1]      ready;
  logic [STAGES:1]      in_valid;
  logic [ID_WIDTH-1:0]  in_id [1:STAGES];
  logic [STAGES:1]      in_clr;
  logic [LANES*PW-1:0]  in_prod;
  logic [SUM_W-1:0]     out_sum;

  assign flush = rst | ~init_n;

  // Ready chain, resolved from the output stage backwards. A stage can load
  // when it is empty or when its own content moves on in the same cycle.
  always_comb begin
    ready         = '0;
    ready[STAGES] = ~valid_q[STAGES] | ~accept_n;
    for (int k = STAGES - 1; k >= 1; k--) begin
      ready[k] = ~valid_q[k] | ready[k+1];
    end
  end

  // What each stage would load: stage 1 from the launch port, the others
  // from their predecessor.
  always_comb begin
    in_valid    = '0;
    in_valid[1] = launch;
    for (int k = 1; k <= STAGES; k++) begin
      in_id[k] = '0;
    end
    in_id[1] = launch_id;
    for (int k = 2; k <= STAGES; k++) begin
      in_valid[k] = valid_q[k-1];
      in_id[k]    = id_q[k-1];
    end
  end

  // Bubbles advance too (a stage loading from an empty predecessor becomes
  // empty), which keeps ops in launch order without inserting gaps. The tag
  // only changes when a real op arrives.
  always_ff @(posedge clk) begin
    if (flush) begin
      valid_q <= '0;
      for (int k = 1; k <= STAGES; k++) begin
        id_q[k] <= '0;
      end
    end else begin
      for (int k = 1; k <= STAGES; k++) begin
        if (ready[k]) begin
          valid_q[k] <= in_valid[k];
          if (in_valid[k]) begin
            id_q[k] <= in_id[k];
          end
        end
      end
    end
  end

  // The clear request is only needed up to the point the op enters the
  // output stage, so only the stages in front of it keep a copy.
  assign in_clr[1] = clr_acc_n;
  for (gi = 1; gi < STAGES; gi++) begin : g_clr
    logic clr_q;
    always_ff @(posedge clk) begin
      if (ready[gi] && in_valid[gi]) begin
        clr_q <= in_clr[gi];
      end
    end
    assign in_clr[gi+1] = clr_q;
  end

  // ---------------------------------------------------------------------
  // Datapath: multiplies at the launch port, lane products registered in
  // stage 1, adder tree between stage 1 and stage 2, then the finished sum
  // travels through the middle stages. With a single stage everything is
  // combinational in front of the accumulator.
  // ---------------------------------------------------------------------
  for (gi = 0; gi < LANES; gi++) begin : g_lane
    assign in_prod[gi*PW +: PW] = mul_lane(a[gi*A_WIDTH +: A_WIDTH],
                                           b[gi*B_WIDTH +: B_WIDTH]);
  end

  if (STAGES == 1) begin : g_direct
    assign out_sum = sum_lanes(in_prod);
  end else begin : g_split
    logic [LANES*PW-1:0] prod_q;
    logic [SUM_W-1:0]    sum_chain [2:STAGES];

    always_ff @(posedge clk) begin
      if (ready[1] && in_valid[1]) begin
        prod_q <= in_prod;
      end
    end

    assign sum_chain[2] = sum_lanes(prod_q);

    for (gi = 2; gi < STAGES; gi++) begin : g_mid
      logic [SUM_W-1:0] sum_q;
      always_ff @(posedge clk) begin
        if (ready[gi] && in_valid[gi]) begin
          sum_q <= sum_chain[gi];
        end
      end
      assign sum_chain[gi+1] = sum_q;
    end

    assign out_sum = sum_chain[STAGES];
  end

  // ---------------------------------------------------------------------
  // Accumulate on entry to the output stage. When the departing result and
  // the incoming op swap in one cycle, acc_q still holds the departing
  // value, which is exactly the base the new op must build on.
  // ---------------------------------------------------------------------
  logic                 out_load;
  logic [ACC_WIDTH-1:0] base;
  logic [RES_W-1:0]     res_full;
  logic [HI_W-1:0]      res_hi;
  logic                 over;
  logic [ACC_WIDTH-1:0] sat_val;
  logic                 clamp;
  logic [ACC_WIDTH-1:0] acc_d;

  assign out_load = ready[STAGES] & in_valid[STAGES];

  always_comb begin
    base     = in_clr[STAGES] ? acc_q : '0;
    res_full = {{(RES_W-SUM_W){(TC != 0) & out_sum[SUM_W-1]}}, out_sum}
             + {{(RES_W-ACC_WIDTH){(TC != 0) & base[ACC_WIDTH-1]}}, base};
    // res_hi covers the accumulator's top bit plus everything above it.
    // Signed results fit when all of those bits agree; unsigned results fit
    // when nothing above the accumulator is set.
    res_hi = res_full[RES_W-1:ACC_WIDTH-1];
    if (TC != 0) begin
      over    = ~((&res_hi) | ~(|res_hi));
      sat_val = res_full[RES_W-1] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                  : {1'b0, {(ACC_WIDTH-1){1'b1}}};
    end else begin
      over    = |res_hi[HI_W-1:1];
      sat_val = '1;
    end
    clamp = (SAT != 0) & over;
    acc_d = clamp ? sat_val : res_full[ACC_WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (flush) begin
      acc_q <= '0;
      ovf_q <= 1'b0;
      sat_q <= 1'b0;
    end else begin
      if (out_load) begin
        acc_q <= acc_d;
        if (clamp) begin
          sat_q <= 1'b1;
        end
      end
      if (launch && !ready[1]) begin
        ovf_q <= 1'b1;
      end
    end
  end

  // Census of occupied stages.
  always_comb begin
    pipe_census = '0;
    for (int k = 1; k <= STAGES; k++) begin
      pipe_census = pipe_census + 3'(valid_q[k]);
    end
  end

  assign acc        = acc_q;
  assign arrive     = valid_q[STAGES];
  assign arrive_id  = id_q[STAGES];
  assign push_out_n = ~(valid_q[STAGES] & ~accept_n);
  assign pipe_full  = ~ready[1];
  assign pipe_ovf   = ovf_q;
  assign sat_flag   = sat_q;

endmodule

// File: tb/tb_piped_dot_mac.sv
// tb_piped_dot_mac -- directed bench for piped_dot_mac.
//
// Four instances share every input: an unsigned 24-bit wrapping unit, a
// signed 24-bit unit, an unsigned 16-bit saturating unit and an unsigned
// 16-bit wrapping unit, all with four 8-bit lanes and two stages. Each
// transaction drives one op; expected values are worked out by hand.
module tb_piped_dot_mac;

  logic        clk = 1'b0;
  logic        rst;
  logic        init_n;
  logic        clr_acc_n;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic        launch;
  logic        launch_id;
  logic        accept_n;

  // unsigned, 24-bit, wrapping
  logic [23:0] d_acc;
  logic        d_arrive, d_arrive_id, d_push_out_n, d_pipe_full, d_pipe_ovf, d_sat_flag;
  logic [2:0]  d_census;
  // signed, 24-bit, wrapping
  logic [23:0] s_acc;
  logic        s_arrive, s_arrive_id, s_push_out_n, s_pipe_full, s_pipe_ovf, s_sat_flag;
  logic [2:0]  s_census;
  // unsigned, 16-bit, saturating
  logic [15:0] t_acc;
  logic        t_arrive, t_arrive_id, t_push_out_n, t_pipe_full, t_pipe_ovf, t_sat_flag;
  logic [2:0]  t_census;
  // unsigned, 16-bit, wrapping
  logic [15:0] w_acc;
  logic        w_arrive, w_arrive_id, w_push_out_n, w_pipe_full, w_pipe_ovf, w_sat_flag;
  logic [2:0]  w_census;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  piped_dot_mac #(.TC(0), .SAT(0), .ACC_WIDTH(24)) u_dut (
    .clk(clk), .rst(rst), .init_n(init_n), .clr_acc_n(clr_acc_n),
    .a(a_in), .b(b_in), .launch(launch), .launch_id(launch_id), .accept_n(accept_n),
    .acc(d_acc), .arrive(d_arrive), .arrive_id(d_arrive_id), .push_out_n(d_push_out_n),
    .pipe_full(d_pipe_full), .pipe_ovf(d_pipe_ovf), .pipe_census(d_census),
    .sat_flag(d_sat_flag)
  );

  piped_dot_mac #(.TC(1), .SAT(0), .ACC_WIDTH(24)) u_sgn (
    .clk(clk), .rst(rst), .init_n(init_n), .clr_acc_n(clr_acc_n),
    .a(a_in), .b(b_in), .launch(launch), .launch_id(launch_id), .accept_n(accept_n),
    .acc(s_acc), .arrive(s_arrive), .arrive_id(s_arrive_id), .push_out_n(s_push_out_n),
    .pipe_full(s_pipe_full), .pipe_ovf(s_pipe_ovf), .pipe_census(s_census),
    .sat_flag(s_sat_flag)
  );

  piped_dot_mac #(.TC(0), .SAT(1), .ACC_WIDTH(16)) u_sat (
    .clk(clk), .rst(rst), .init_n(init_n), .clr_acc_n(clr_acc_n),
    .a(a_in), .b(b_in), .launch(launch), .launch_id(launch_id), .accept_n(accept_n),
    .acc(t_acc), .arrive(t_arrive), .arrive_id(t_arrive_id), .push_out_n(t_push_out_n),
    .pipe_full(t_pipe_full), .pipe_ovf(t_pipe_ovf), .pipe_census(t_census),
    .sat_flag(t_sat_flag)
  );

  piped_dot_mac #(.TC(0), .SAT(0), .ACC_WIDTH(16)) u_wrap (
    .clk(clk), .rst(rst), .init_n(init_n), .clr_acc_n(clr_acc_n),
    .a(a_in), .b(b_in), .launch(launch), .launch_id(launch_id), .accept_n(accept_n),
    .acc(w_acc), .arrive(w_arrive), .arrive_id(w_arrive_id), .push_out_n(w_push_out_n),
    .pipe_full(w_pipe_full), .pipe_ovf(w_pipe_ovf), .pipe_census(w_census),
    .sat_flag(w_sat_flag)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just past the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_op(input logic [31:0] av, input logic [31:0] bv,
                          input logic clr_n, input logic id);
    a_in      = av;
    b_in      = bv;
    clr_acc_n = clr_n;
    launch_id = id;
    launch    = 1'b1;
    $display("op t=%0t a=0x%08h b=0x%08h clr_acc_n=%0b id=%0d accept_n=%0b init_n=%0b",
             $time, av, bv, clr_n, id, accept_n, init_n);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    rst       = 1'b1;
    init_n    = 1'b1;
    clr_acc_n = 1'b1;
    a_in      = 32'h0;
    b_in      = 32'h0;
    launch    = 1'b1;
    launch_id = 1'b0;
    accept_n  = 1'b1;

    // Reset held for two cycles with launch asserted.
    step();
    step();
    check_eq("rst_acc",       32'(d_acc),        32'h0);
    check_eq("rst_arrive",    32'(d_arrive),     32'h0);
    check_eq("rst_arrive_id", 32'(d_arrive_id),  32'h0);
    check_eq("rst_push_n",    32'(d_push_out_n), 32'h1);
    check_eq("rst_census",    32'(d_census),     32'h0);
    check_eq("rst_full",      32'(d_pipe_full),  32'h0);
    check_eq("rst_ovf",       32'(d_pipe_ovf),   32'h0);
    check_eq("rst_sat",       32'(t_sat_flag),   32'h0);

    // Basic accumulate: 1*5+2*6+3*7+4*8 = 70, then 70 again on top.
    rst      = 1'b0;
    launch   = 1'b0;
    accept_n = 1'b0;
    drive_op(32'h04030201, 32'h08070605, 1'b0, 1'b0);
    step();
    check_eq("basic_census1", 32'(d_census), 32'h1);
    check_eq("basic_arrive0", 32'(d_arrive), 32'h0);
    drive_op(32'h04030201, 32'h08070605, 1'b1, 1'b1);
    step();
    check_eq("basic_arrive",  32'(d_arrive),     32'h1);
    check_eq("basic_acc70",   32'(d_acc),        32'd70);
    check_eq("basic_push_n",  32'(d_push_out_n), 32'h0);
    check_eq("basic_id0",     32'(d_arrive_id),  32'h0);
    check_eq("basic_census2", 32'(d_census),     32'h2);
    launch = 1'b0;
    step();
    check_eq("basic_acc140",  32'(d_acc),        32'd140);
    check_eq("basic_id1",     32'(d_arrive_id),  32'h1);
    check_eq("basic_arrive2", 32'(d_arrive),     32'h1);
    step();
    check_eq("basic_drained", 32'(d_arrive),     32'h0);
    check_eq("basic_census0", 32'(d_census),     32'h0);
    check_eq("basic_hold",    32'(d_acc),        32'd140);
    check_eq("basic_push_n1", 32'(d_push_out_n), 32'h1);

    // Backpressure: three back-to-back launches while the consumer stalls.
    accept_n = 1'b1;
    drive_op(32'h01010101, 32'h01010101, 1'b0, 1'b0);
    step();
    check_eq("bp_census1", 32'(d_census),    32'h1);
    check_eq("bp_full0",   32'(d_pipe_full), 32'h0);
    drive_op(32'h01010101, 32'h01010101, 1'b1, 1'b1);
    step();
    check_eq("bp_census2", 32'(d_census),     32'h2);
    check_eq("bp_full1",   32'(d_pipe_full),  32'h1);
    check_eq("bp_acc4",    32'(d_acc),        32'd4);
    check_eq("bp_push_n",  32'(d_push_out_n), 32'h1);
    drive_op(32'h01010101, 32'h01010101, 1'b1, 1'b1);
    step();
    check_eq("bp_drop_census", 32'(d_census),    32'h2);
    check_eq("bp_ovf",         32'(d_pipe_ovf),  32'h1);
    check_eq("bp_stall_acc",   32'(d_acc),       32'd4);
    check_eq("bp_stall_id",    32'(d_arrive_id), 32'h0);
    launch = 1'b0;
    step();
    check_eq("bp_ovf_sticky", 32'(d_pipe_ovf), 32'h1);
    check_eq("bp_acc_stable", 32'(d_acc),      32'd4);
    accept_n = 1'b0;
    step();
    check_eq("bp_arr_id1", 32'(d_arrive_id), 32'h1);
    check_eq("bp_acc8",    32'(d_acc),       32'd8);
    check_eq("bp_census",  32'(d_census),    32'h1);
    step();
    check_eq("bp_empty",     32'(d_census),   32'h0);
    check_eq("bp_no_arrive", 32'(d_arrive),   32'h0);
    check_eq("bp_ovf_kept",  32'(d_pipe_ovf), 32'h1);

    // Signed: (-128)*(-128)*4 = 65536, then cleared (-1)*1*4 = -4.
    drive_op(32'h80808080, 32'h80808080, 1'b0, 1'b0);
    step();
    drive_op(32'hFFFFFFFF, 32'h01010101, 1'b0, 1'b1);
    step();
    check_eq("tc_acc_65536", 32'(s_acc),      32'h010000);
    check_eq("tc_u_65536",   32'(d_acc),      32'h010000);
    check_eq("tc_sat_clamp", 32'(t_acc),      32'hFFFF);
    check_eq("tc_sat_flag",  32'(t_sat_flag), 32'h1);
    check_eq("tc_wrap_0",    32'(w_acc),      32'h0);
    check_eq("tc_nosat",     32'(d_sat_flag), 32'h0);
    launch = 1'b0;
    step();
    check_eq("tc_acc_neg4",  32'(s_acc),       32'hFFFFFC);
    check_eq("tc_id1",       32'(s_arrive_id), 32'h1);
    check_eq("tc_u_1020",    32'(d_acc),       32'h3FC);
    check_eq("tc_sat_clr",   32'(t_acc),       32'h3FC);
    check_eq("tc_sat_stick", 32'(t_sat_flag),  32'h1);
    check_eq("tc_wrap_1020", 32'(w_acc),       32'h3FC);
    step();

    // Soft init with two ops in flight; the launch in the init cycle is ignored.
    accept_n = 1'b1;
    drive_op(32'h01010101, 32'h01010101, 1'b1, 1'b0);
    step();
    drive_op(32'h01010101, 32'h01010101, 1'b1, 1'b1);
    step();
    check_eq("init_pre_census", 32'(d_census), 32'h2);
    init_n = 1'b0;
    drive_op(32'h02020202, 32'h02020202, 1'b1, 1'b0);
    step();
    check_eq("init_census", 32'(d_census),   32'h0);
    check_eq("init_arrive", 32'(d_arrive),   32'h0);
    check_eq("init_acc",    32'(d_acc),      32'h0);
    check_eq("init_ovf",    32'(d_pipe_ovf), 32'h0);
    check_eq("init_sat",    32'(t_sat_flag), 32'h0);
    check_eq("init_s_acc",  32'(s_acc),      32'h0);
    check_eq("init_full",   32'(d_pipe_full), 32'h0);
    init_n   = 1'b1;
    launch   = 1'b0;
    accept_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check_eq("init_no_ghost", 32'(d_arrive), 32'h0);
    end
    check_eq("init_acc_kept", 32'(d_acc), 32'h0);

    // Saturation: 255*255*4 = 260100 clamps at 16 bits, wraps to 0xF804.
    drive_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0);
    step();
    drive_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1);
    step();
    check_eq("sat_acc",     32'(t_acc),      32'hFFFF);
    check_eq("sat_flag",    32'(t_sat_flag), 32'h1);
    check_eq("wrap_acc",    32'(w_acc),      32'hF804);
    check_eq("wide_acc",    32'(d_acc),      32'h03F804);
    check_eq("sgn_acc4",    32'(s_acc),      32'h4);
    check_eq("wrap_nosat",  32'(w_sat_flag), 32'h0);
    launch = 1'b0;
    step();
    check_eq("sat_hold_max", 32'(t_acc), 32'hFFFF);
    check_eq("wide_acc2",    32'(d_acc), 32'h07F008);
    check_eq("wrap_acc2",    32'(w_acc), 32'hF008);
    check_eq("sgn_acc8",     32'(s_acc), 32'h8);
    step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/piped_dot_mac.md
Name: piped_dot_mac

Overview:
Multi-lane pipelined multiply-accumulate engine and next generation of the single-lane piped MAC. Each launched operation computes a LANES-wide dot product and adds it to a running accumulator. Pipeline depth is parameterised, with launch/arrive handshaking, ID tagging, output backpressure, census, and optional saturation. The block sits between an operand sequencer and a result consumer in the DSP datapath.

Parameters:
A_WIDTH, 8, width of each a lane (>=2)
B_WIDTH, 8, width of each b lane (>=2)
LANES, 4, number of product lanes (1..16)
ACC_WIDTH, 24, accumulator width (>= A_WIDTH+B_WIDTH)
TC, 0, 0 = unsigned operands and accumulator, 1 = two's complement
STAGES, 2, pipeline depth from launch to arrive (1..7)
ID_WIDTH, 1, width of the launch/arrive tag
SAT, 0, 0 = accumulator wraps modulo 2^ACC_WIDTH, 1 = accumulator clamps

Ports:
clk  in  1  clock, all state updates on the rising edge
rst  in  1  reset, synchronous and active-high
init_n  in  1  synchronous soft init, active-low
clr_acc_n  in  1  active-low, sampled with launch; this op uses 0 as accumulator base
a  in  LANES*A_WIDTH  operand lanes, lane i = a[i*A_WIDTH +: A_WIDTH]
b  in  LANES*B_WIDTH  operand lanes, same packing as a
launch  in  1  operation request
launch_id  in  ID_WIDTH  tag carried with the operation
accept_n  in  1  active-low; consumer takes the result in the output stage
acc  out  ACC_WIDTH  accumulator register
arrive  out  1  output stage holds a valid result
arrive_id  out  ID_WIDTH  tag of the result in the output stage
push_out_n  out  1  active-low; equals ~(arrive & ~accept_n), combinational
pipe_full  out  1  no launch can be accepted this cycle
pipe_ovf  out  1  sticky flag: a launch was dropped
pipe_census  out  3  number of valid stages, 0..STAGES
sat_flag  out  1  sticky flag: a clamp occurred (only when SAT=1)

Behaviour:
- Reset: rst=1 clears all stage valid bits, acc, pipe_ovf and sat_flag.
  - Outputs after reset: acc=0, arrive=0, arrive_id=0, push_out_n=1, pipe_full=0, pipe_census=0, sat_flag=0.
  - rst has priority over every other input.
- init_n=0 (rst=0) has the same effect as rst. launch is ignored in that cycle.
- Pipeline stages 1..STAGES, each with a valid bit and an ID. Stage STAGES is the output stage.
- Ready chain:
  - ready[STAGES] = ~valid[STAGES] | ~accept_n
  - ready[k] = ~valid[k] | ready[k+1]
  - Stage k loads from stage k-1 when ready[k]=1; otherwise it holds.
  - Stage 1 loads launch, launch_id, clr_acc_n and operands when ready[1]=1.
- pipe_full = ~ready[1] (combinational).
  - launch while pipe_full=1: operation dropped, pipe_ovf set next cycle, stays set until rst or init_n.
- Latency: with no stall, launch at cycle t gives arrive=1 at t+STAGES.
  - Ops remain in launch order; no bubbles are inserted.
- Accumulation:
  - When an op loads into the output stage: acc <= base + sum(a_i*b_i), where base = 0 if the op's clr_acc_n=0, else current acc.
  - acc is stable while the result is held (arrive=1, accept_n=1).
  - Simultaneous accept of the output op and load of the next op in the same cycle is legal; the new op accumulates onto the departing result.
  - acc retains its value when no op enters the output stage.
- Arithmetic:
  - TC=0: products and sum are zero-extended.
  - TC=1: products and sum are sign-extended.
  - The sum is formed at full precision (A_WIDTH+B_WIDTH+ceil(log2 LANES)+1 bits), then added to base.
  - SAT=0: result truncated to ACC_WIDTH.
  - SAT=1: result clamped to the ACC_WIDTH max/min for the TC mode, and sat_flag set (sticky).
  - Internal placement of multiplies and adds across stages is free; only the visible latency is fixed.
- pipe_census = count of valid stages, updated every cycle; zero-extended to 3 bits.

Test Plan:
- Reset: drive rst=1 for 2 cycles with launch=1 -> acc=0, arrive=0, push_out_n=1, census=0, pipe_full=0, pipe_ovf=0.
- Basic accumulate (STAGES=2, accept_n=0):
  - At t: a={1,2,3,4}, b={5,6,7,8}, clr_acc_n=0, id=0 -> at t+2: arrive=1, acc=70, push_out_n=0.
  - At t+1: same operands, clr_acc_n=1, id=1 -> at t+3: acc=140, arrive_id=1.
- Backpressure, 3 launches back-to-back with accept_n=1:
  - census sequence 1,2,2; pipe_full=1 after the second launch.
  - Third launch dropped; pipe_ovf=1 and stays set.
  - accept_n=0 -> two arrivals with ids 0 then 1, then census=0.
- Signed (TC=1, clr):
  - All lanes a=b=-128 -> acc=65536.
  - Next op with clr: a=-1, b=1 on all lanes -> acc=0xFFFFFC.
- Saturation (SAT=1, ACC_WIDTH=16, TC=0): all lanes a=b=255 with clr -> acc=0xFFFF, sat_flag=1. The same case with SAT=0 gives acc=260100 mod 65536 = 0xF804.
- Init mid-flight: two ops in flight, pulse init_n=0 for 1 cycle -> next cycle census=0, arrive=0, acc=0, pipe_ovf=0; no result ever arrives for the flushed ops.
